// File: rtl/pm_capture_ctrl.sv
// Postmortem capture sequencer: streams samples into a circular DDR buffer
// through a single-beat writer and freezes POST_CNT samples after a fault edge.
module pm_capture_ctrl #(
    parameter logic [39:0] BASE_ADDR = 40'h00_1000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          IDX_W     = 10,
    parameter int          POST_CNT  = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_arm,
    input  logic             i_clr,
    input  logic             i_fault,
    input  logic             i_sample_valid,
    input  logic [63:0]      i_sample_data,
    output logic             o_start,
    input  logic             i_done,
    output logic [39:0]      o_ddr_addr,
    output logic [63:0]      o_ddr_data,
    output logic [1:0]       o_state,
    output logic             o_busy,
    output logic [IDX_W-1:0] o_wr_idx,
    output logic [IDX_W-1:0] o_trig_idx,
    output logic             o_wrap,
    output logic [15:0]      o_drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LP_POST = IDX_W'(POST_CNT);

    state_t           r_state, w_state_nxt;
    logic             r_fault_q;
    logic             r_slot_full, r_slot_tag;
    logic [63:0]      r_slot_data;
    logic             r_start, r_busy;
    logic [39:0]      r_addr;
    logic [63:0]      r_data;
    logic [IDX_W-1:0] r_wr_idx, r_trig_idx, r_post_remain;
    logic             r_wrap, r_trig_seen;
    logic [15:0]      r_drop_cnt;

    logic w_edge, w_active, w_issue, w_take, w_load, w_drop, w_arm;

    // A done pulse frees the writer this cycle, so the held entry can issue
    // on the same edge and o_start appears the cycle after i_done.
    assign w_edge   = i_fault & ~r_fault_q;
    assign w_active = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_issue  = w_active & r_slot_full & (~r_busy | i_done);
    assign w_take   = i_sample_valid &
                      ((r_state == S_ARMED) || ((r_state == S_POST) && (r_post_remain != '0)));
    assign w_load   = w_take & (~r_slot_full | w_issue);
    assign w_drop   = w_take & ~w_load;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; arm strobe only honoured from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_arm) begin
                    w_state_nxt = S_ARMED;
                    w_arm       = 1'b1;
                end
            end
            S_ARMED: begin
                if (w_edge) w_state_nxt = S_POST;
            end
            S_POST: begin
                if ((r_post_remain == '0) && !r_slot_full && !r_busy) w_state_nxt = S_FROZEN;
            end
            S_FROZEN: begin
                if (i_clr) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Holding slot, issue register, indices and counters
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_fault_q     <= 1'b0;
            r_slot_full   <= 1'b0;
            r_slot_tag    <= 1'b0;
            r_slot_data   <= '0;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_wr_idx      <= '0;
            r_trig_idx    <= '0;
            r_post_remain <= '0;
            r_wrap        <= 1'b0;
            r_trig_seen   <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_fault_q <= i_fault;
            r_start   <= w_issue;

            if (w_issue)     r_busy <= 1'b1;
            else if (i_done) r_busy <= 1'b0;

            if (w_load) begin
                r_slot_full <= 1'b1;
                r_slot_tag  <= (r_state == S_POST);
                r_slot_data <= i_sample_data;
            end else if (w_issue) begin
                r_slot_full <= 1'b0;
            end

            if (w_load && (r_state == S_POST)) r_post_remain <= r_post_remain - 1'b1;

            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;

            if (w_issue) begin
                r_addr <= BASE_ADDR + 40'({r_wr_idx, 3'b000});
                r_data <= r_slot_data;
                if (r_wr_idx == LP_LAST) begin
                    r_wr_idx <= '0;
                    r_wrap   <= 1'b1;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
                if (r_slot_tag && !r_trig_seen) begin
                    r_trig_idx  <= r_wr_idx;
                    r_trig_seen <= 1'b1;
                end
            end

            // Arm only happens from IDLE where nothing issues or loads
            if (w_arm) begin
                r_wr_idx      <= '0;
                r_wrap        <= 1'b0;
                r_trig_idx    <= '0;
                r_trig_seen   <= 1'b0;
                r_drop_cnt    <= '0;
                r_post_remain <= LP_POST;
            end
        end
    end

    assign o_start    = r_start;
    assign o_ddr_addr = r_addr;
    assign o_ddr_data = r_data;
    assign o_state    = r_state;
    assign o_busy     = r_busy;
    assign o_wr_idx   = r_wr_idx;
    assign o_trig_idx = r_trig_idx;
    assign o_wrap     = r_wrap;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pm_capture_ctrl.sv
// Directed bench for pm_capture_ctrl with a writer model answering done
// three cycles after each start.
module tb_pm_capture_ctrl;

    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             i_rst, i_arm, i_clr, i_fault, i_sample_valid;
    logic [63:0]      i_sample_data;
    logic             o_start;
    logic             i_done = 1'b0;
    logic [39:0]      o_ddr_addr;
    logic [63:0]      o_ddr_data;
    logic [1:0]       o_state;
    logic             o_busy;
    logic [IDX_W-1:0] o_wr_idx, o_trig_idx;
    logic             o_wrap;
    logic [15:0]      o_drop_cnt;

    pm_capture_ctrl #(
        .BASE_ADDR(40'h100), .DEPTH(8), .IDX_W(IDX_W), .POST_CNT(3)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_arm(i_arm), .i_clr(i_clr), .i_fault(i_fault),
        .i_sample_valid(i_sample_valid), .i_sample_data(i_sample_data),
        .o_start(o_start), .i_done(i_done), .o_ddr_addr(o_ddr_addr),
        .o_ddr_data(o_ddr_data), .o_state(o_state), .o_busy(o_busy),
        .o_wr_idx(o_wr_idx), .o_trig_idx(o_trig_idx), .o_wrap(o_wrap),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    // Writer model: start seen in cycle s -> done high in cycle s+3
    logic [1:0] wcnt = 2'd0;
    always @(posedge clk) begin
        i_done <= 1'b0;
        if (wcnt == 2'd2) begin
            i_done <= 1'b1;
            wcnt   <= 2'd0;
        end else if (wcnt != 2'd0) begin
            wcnt <= wcnt + 2'd1;
        end
        if (o_start) wcnt <= 2'd1;
    end

    // Log of every issued write
    logic [39:0] lg_addr[$];
    logic [63:0] lg_data[$];
    always @(negedge clk) begin
        if (o_start) begin
            lg_addr.push_back(o_ddr_addr);
            lg_data.push_back(o_ddr_data);
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " start"}, 64'(o_start), 64'd0);
        chk({tag, " addr"}, 64'(o_ddr_addr), 64'd0);
        chk({tag, " data"}, o_ddr_data, 64'd0);
        chk({tag, " state"}, 64'(o_state), 64'd0);
        chk({tag, " busy"}, 64'(o_busy), 64'd0);
        chk({tag, " wr_idx"}, 64'(o_wr_idx), 64'd0);
        chk({tag, " trig_idx"}, 64'(o_trig_idx), 64'd0);
        chk({tag, " wrap"}, 64'(o_wrap), 64'd0);
        chk({tag, " drop"}, 64'(o_drop_cnt), 64'd0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset1();
        i_rst = 1'b0;
        cyc(1);
        i_rst = 1'b1;
    endtask

    task automatic pulse_arm();
        i_arm = 1'b1; cyc(1); i_arm = 1'b0;
    endtask

    task automatic pulse_clr();
        i_clr = 1'b1; cyc(1); i_clr = 1'b0;
    endtask

    // One sample then five idle cycles: enough for a full write to complete
    task automatic samp(input logic [63:0] d);
        i_sample_valid = 1'b1; i_sample_data = d;
        cyc(1);
        i_sample_valid = 1'b0;
        cyc(5);
    endtask

    task automatic chk_log(input string nm, input int k, input logic [39:0] a, input logic [63:0] d);
        if (lg_addr.size() > k) begin
            chk({nm, " addr"}, 64'(lg_addr[k]), 64'(a));
            chk({nm, " data"}, lg_data[k], d);
        end else begin
            chk({nm, " present"}, 64'(lg_addr.size()), 64'(k + 1));
        end
    endtask

    typedef struct {
        logic        arm;
        logic        sv;
        logic [63:0] d;
        logic        e_start;
        logic        e_ad;
        logic [39:0] e_addr;
        logic [63:0] e_data;
        logic        e_busy;
        logic [2:0]  e_idx;
        logic [15:0] e_drop;
    } vec_t;

    vec_t tv[17];

    initial begin
        // Row r drives cycle r; expectations are the outputs one edge later.
        tv[0]  = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b0, 3'd0, 16'd0};
        tv[1]  = '{1'b0, 1'b1, 64'hA5, 1'b0, 1'b0, 40'h0,   64'h0,  1'b0, 3'd0, 16'd0};
        tv[2]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 40'h100, 64'hA5, 1'b1, 3'd1, 16'd0};
        tv[3]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b1, 3'd1, 16'd0};
        tv[4]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b1, 3'd1, 16'd0};
        tv[5]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b1, 3'd1, 16'd0};
        tv[6]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b0, 3'd1, 16'd0};
        tv[7]  = '{1'b0, 1'b1, 64'hB1, 1'b0, 1'b0, 40'h0,   64'h0,  1'b0, 3'd1, 16'd0};
        tv[8]  = '{1'b0, 1'b1, 64'hB2, 1'b1, 1'b1, 40'h108, 64'hB1, 1'b1, 3'd2, 16'd0};
        tv[9]  = '{1'b0, 1'b1, 64'hB3, 1'b0, 1'b0, 40'h0,   64'h0,  1'b1, 3'd2, 16'd1};
        tv[10] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b1, 3'd2, 16'd1};
        tv[11] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b1, 3'd2, 16'd1};
        tv[12] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 40'h110, 64'hB2, 1'b1, 3'd3, 16'd1};
        tv[13] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b1, 3'd3, 16'd1};
        tv[14] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b1, 3'd3, 16'd1};
        tv[15] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b1, 3'd3, 16'd1};
        tv[16] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 40'h0,   64'h0,  1'b0, 3'd3, 16'd1};

        i_rst = 1'b0; i_arm = 1'b0; i_clr = 1'b0; i_fault = 1'b0;
        i_sample_valid = 1'b0; i_sample_data = '0;
        cyc(3);
        chk_zero("reset");
        i_rst = 1'b1;

        // Samples in IDLE are ignored
        i_sample_valid = 1'b1; i_sample_data = 64'hDEAD;
        cyc(1);
        i_sample_valid = 1'b0;
        cyc(4);
        chk("idle no write", 64'(lg_addr.size()), 64'd0);
        chk("idle drop", 64'(o_drop_cnt), 64'd0);
        chk("idle state", 64'(o_state), 64'd0);

        // Basic write, then back-pressure with same-cycle issue/load and a drop
        for (int r = 0; r < 17; r++) begin
            i_arm = tv[r].arm; i_sample_valid = tv[r].sv; i_sample_data = tv[r].d;
            cyc(1);
            chk($sformatf("row%0d start", r), 64'(o_start), 64'(tv[r].e_start));
            chk($sformatf("row%0d busy", r), 64'(o_busy), 64'(tv[r].e_busy));
            chk($sformatf("row%0d wr_idx", r), 64'(o_wr_idx), 64'(tv[r].e_idx));
            chk($sformatf("row%0d drop", r), 64'(o_drop_cnt), 64'(tv[r].e_drop));
            chk($sformatf("row%0d state", r), 64'(o_state), 64'd1);
            if (tv[r].e_ad) begin
                chk($sformatf("row%0d addr", r), 64'(o_ddr_addr), 64'(tv[r].e_addr));
                chk($sformatf("row%0d data", r), o_ddr_data, tv[r].e_data);
            end
        end
        i_arm = 1'b0; i_sample_valid = 1'b0;
        chk("bp writes", 64'(lg_addr.size()), 64'd3);

        // clr and arm are ignored while ARMED
        pulse_clr();
        pulse_arm();
        cyc(1);
        chk("clr in armed state", 64'(o_state), 64'd1);
        chk("arm in armed idx", 64'(o_wr_idx), 64'd3);
        chk("arm in armed drop", 64'(o_drop_cnt), 64'd1);

        // Wrap
        reset1();
        lg_addr.delete(); lg_data.delete();
        pulse_arm();
        for (int k = 0; k < 9; k++) begin
            samp(64'h200 + 64'(k));
            if (k == 6) chk("wrap before 8th", 64'(o_wrap), 64'd0);
            if (k == 7) begin
                chk("wrap at 8th", 64'(o_wrap), 64'd1);
                chk("idx at 8th", 64'(o_wr_idx), 64'd0);
            end
        end
        chk_log("wrap 8th", 7, 40'h138, 64'h207);
        chk_log("wrap 9th", 8, 40'h100, 64'h208);
        chk("wrap idx", 64'(o_wr_idx), 64'd1);
        chk("wrap flag", 64'(o_wrap), 64'd1);

        // Trigger: 5 pre, fault edge, 5 offered post (only 3 taken)
        reset1();
        lg_addr.delete(); lg_data.delete();
        pulse_arm();
        for (int k = 0; k < 5; k++) samp(64'h300 + 64'(k));
        i_fault = 1'b1;
        cyc(1);
        chk("trig state post", 64'(o_state), 64'd2);
        pulse_arm();
        for (int k = 0; k < 5; k++) samp(64'h310 + 64'(k));
        cyc(4);
        chk("trig writes", 64'(lg_addr.size()), 64'd8);
        chk_log("post0", 5, 40'h128, 64'h310);
        chk_log("post1", 6, 40'h130, 64'h311);
        chk_log("post2", 7, 40'h138, 64'h312);
        chk("trig_idx", 64'(o_trig_idx), 64'd5);
        chk("frozen", 64'(o_state), 64'd3);
        chk("trig drop", 64'(o_drop_cnt), 64'd0);
        chk("trig wr_idx", 64'(o_wr_idx), 64'd0);
        chk("trig wrap", 64'(o_wrap), 64'd1);
        pulse_arm();
        chk("arm in frozen", 64'(o_state), 64'd3);
        pulse_clr();
        chk("clr to idle", 64'(o_state), 64'd0);
        chk("held trig_idx", 64'(o_trig_idx), 64'd5);
        chk("held wrap", 64'(o_wrap), 64'd1);
        pulse_arm();
        chk("rearm trig_idx", 64'(o_trig_idx), 64'd0);
        chk("rearm wrap", 64'(o_wrap), 64'd0);
        chk("rearm state", 64'(o_state), 64'd1);
        i_fault = 1'b0;

        // Sample in the fault-edge cycle is pre-trigger
        reset1();
        lg_addr.delete(); lg_data.delete();
        pulse_arm();
        samp(64'h400);
        samp(64'h401);
        i_fault = 1'b1;
        samp(64'h4C2);
        chk("edge state", 64'(o_state), 64'd2);
        for (int k = 0; k < 3; k++) samp(64'h410 + 64'(k));
        cyc(4);
        chk("edge writes", 64'(lg_addr.size()), 64'd6);
        chk_log("edge sample", 2, 40'h110, 64'h4C2);
        chk_log("edge first post", 3, 40'h118, 64'h410);
        chk("edge trig_idx", 64'(o_trig_idx), 64'd3);
        chk("edge wr_idx", 64'(o_wr_idx), 64'd6);
        chk("edge frozen", 64'(o_state), 64'd3);
        i_fault = 1'b0;

        // Reset between start and done
        reset1();
        lg_addr.delete(); lg_data.delete();
        pulse_arm();
        i_sample_valid = 1'b1; i_sample_data = 64'h55;
        cyc(1);
        i_sample_valid = 1'b0;
        cyc(1);
        chk("midrst start seen", 64'(o_start), 64'd1);
        reset1();
        chk_zero("midrst");
        cyc(4);
        chk("late done busy", 64'(o_busy), 64'd0);
        chk("late done state", 64'(o_state), 64'd0);
        lg_addr.delete(); lg_data.delete();
        pulse_arm();
        samp(64'h66);
        chk_log("after midrst", 0, 40'h100, 64'h66);
        chk("after midrst idx", 64'(o_wr_idx), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
